univ_shift_reg: RTL and testbench

Parametrised universal shift register and the successor of the single-bit SISO shifter. It adds configurable width, bidirectional serial shift, parallel load and parallel readout, so one block covers SISO, SIPO, PISO and PIPO use. A shift counter flags each completed word so serial-link logic can frame data without an external counter.

---
 rtl/univ_shift_reg.sv | 118 +++++++++++
 tb/tb_univ_shift_reg.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : Parametrised universal shift register. It supports hold,
//            right shift, left shift and parallel load, with serial and
//            parallel outputs. A shared shift counter pulses word_done on
//            every WIDTH-th shift so serial-link logic can frame words.
// Options  : UNIV_SR_ROTATE_EN adds the 'rot' input. When rot=1, modes 01
//            and 10 rotate instead of taking the serial inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,      // asynchronous, active-low
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         din_sr,
    input  logic                         din_sl,
    input  logic [WIDTH-1:0]             pdin,
`ifdef UNIV_SR_ROTATE_EN
    input  logic                         rot,
`endif
    output logic                         dout_r,
    output logic                         dout_l,
    output logic [WIDTH-1:0]             pdout,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         word_done
);

    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wd_q, wd_d;

    // Bits entering the register at each end. Rotation feeds back the bit
    // that leaves the opposite end, so the serial inputs are ignored.
    logic w_in_right;   // enters the MSB on a right shift
    logic w_in_left;    // enters the LSB on a left shift
    logic w_shift;      // this cycle performs a counted shift or rotation

`ifdef UNIV_SR_ROTATE_EN
    assign w_in_right = rot ? q_q[0]       : din_sr;
    assign w_in_left  = rot ? q_q[WIDTH-1] : din_sl;
`else
    assign w_in_right = din_sr;
    assign w_in_left  = din_sl;
`endif

    // Next-state logic: the mode selects the data path. Shifts advance the
    // word counter, and a load discards any partial count.
    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        wd_d    = 1'b0;
        w_shift = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHR: begin
                    q_d     = {w_in_right, q_q[WIDTH-1:1]};
                    w_shift = 1'b1;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], w_in_left};
                    w_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = pdin;
                    cnt_d = '0;
                end
                MODE_HOLD: begin
                end
                default: begin
                end
            endcase
        end
        if (w_shift) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                wd_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers. The reset takes effect asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= RESET_VAL;
            cnt_q <= '0;
            wd_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
            wd_q  <= wd_d;
        end
    end

    assign pdout     = q_q;
    assign dout_r    = q_q[0];
    assign dout_l    = q_q[WIDTH-1];
    assign shift_cnt = cnt_q;
    assign word_done = wd_q;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Directed self-checking bench for univ_shift_reg
//            (WIDTH=8, RESET_VAL=8'hA5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic             din_sr;
    logic             din_sl;
    logic [7:0]       pdin;
`ifdef UNIV_SR_ROTATE_EN
    logic             rot;
`endif
    logic             dout_r;
    logic             dout_l;
    logic [7:0]       pdout;
    logic [3:0]       shift_cnt;
    logic             word_done;

    int checks   = 0;
    int failures = 0;

    univ_shift_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .din_sr    (din_sr),
        .din_sl    (din_sl),
        .pdin      (pdin),
`ifdef UNIV_SR_ROTATE_EN
        .rot       (rot),
`endif
        .dout_r    (dout_r),
        .dout_l    (dout_l),
        .pdout     (pdout),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; mode = 2'b00; din_sr = 1'b0; din_sl = 1'b0; pdin = 8'h00;
        #2;
        reset = 1'b0;   // asserted mid-cycle, before any clock edge
        #1;
        checks++;
        if (pdout !== 8'hA5) begin failures++; $display("FAIL reset_pdout got=%h exp=%h", pdout, 8'hA5); end
        checks++;
        if (shift_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
        checks++;
        if (word_done !== 1'b0) begin failures++; $display("FAIL reset_wd got=%b exp=0", word_done); end
        checks++;
        if (dout_r !== 1'b1 || dout_l !== 1'b1) begin
            failures++; $display("FAIL reset_dout got r=%b l=%b exp r=1 l=1", dout_r, dout_l);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (pdout !== 8'hA5) begin failures++; $display("FAIL reset_release_hold got=%h exp=a5", pdout); end
    endtask

    task automatic test_siso_right();
        logic [7:0] seq;
        seq = 8'b0010_1100;   // bit i is the i-th bit presented: 0,0,1,1,0,1,0,0
        en = 1'b1; mode = 2'b01;
        for (int i = 0; i < 8; i++) begin
            din_sr = seq[i];
            tick();
            checks++;
            if (word_done !== (i == 7)) begin
                failures++; $display("FAIL siso_wd edge=%0d got=%b exp=%b", i + 1, word_done, (i == 7));
            end
        end
        checks++;
        if (pdout !== 8'h2C) begin failures++; $display("FAIL siso_pdout got=%h exp=2c", pdout); end
        // The presented sequence now replays on dout_r.
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dout_r !== seq[i]) begin
                failures++; $display("FAIL siso_replay bit=%0d got=%b exp=%b", i, dout_r, seq[i]);
            end
            din_sr = 1'b0;
            tick();
        end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_piso_left();
        logic [7:0] exp_bits;
        exp_bits = 8'b1100_0011;   // dout_l before each shift, MSB first
        en = 1'b1; mode = 2'b11; pdin = 8'hC3;
        tick();
        checks++;
        if (pdout !== 8'hC3 || shift_cnt !== 4'd0) begin
            failures++; $display("FAIL piso_load got=%h cnt=%0d exp=c3 cnt=0", pdout, shift_cnt);
        end
        mode = 2'b10; din_sl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dout_l !== exp_bits[7-i]) begin
                failures++; $display("FAIL piso_dout_l bit=%0d got=%b exp=%b", i, dout_l, exp_bits[7-i]);
            end
            tick();
        end
        checks++;
        if (pdout !== 8'h00 || word_done !== 1'b1) begin
            failures++; $display("FAIL piso_end got=%h wd=%b exp=00 wd=1", pdout, word_done);
        end
        mode = 2'b00;
        tick();
        checks++;
        if (word_done !== 1'b0) begin failures++; $display("FAIL piso_wd_drop got=%b exp=0", word_done); end
    endtask

    task automatic test_partial_load();
        logic [7:0] exp_q [8];
        exp_q = '{8'h79, 8'hF3, 8'hE7, 8'hCF, 8'h9F, 8'h3F, 8'h7F, 8'hFF};
        en = 1'b1; mode = 2'b01; din_sr = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (pdout !== 8'hF8 || shift_cnt !== 4'd5) begin
            failures++; $display("FAIL partial_shift got=%h cnt=%0d exp=f8 cnt=5", pdout, shift_cnt);
        end
        mode = 2'b11; pdin = 8'h3C;
        tick();
        checks++;
        if (pdout !== 8'h3C || shift_cnt !== 4'd0 || word_done !== 1'b0) begin
            failures++; $display("FAIL partial_load got=%h cnt=%0d wd=%b exp=3c cnt=0 wd=0", pdout, shift_cnt, word_done);
        end
        mode = 2'b10; din_sl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (pdout !== exp_q[i] || word_done !== (i == 7)) begin
                failures++; $display("FAIL partial_reshift shift=%0d got=%h wd=%b exp=%h wd=%b",
                                     i + 1, pdout, word_done, exp_q[i], (i == 7));
            end
        end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_enable_freeze();
        logic [7:0] exp_q [5];
        exp_q = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07};
        en = 1'b1; mode = 2'b11; pdin = 8'hF0;
        tick();
        mode = 2'b01; din_sr = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pdout !== 8'hFE || shift_cnt !== 4'd3) begin
            failures++; $display("FAIL freeze_pre got=%h cnt=%0d exp=fe cnt=3", pdout, shift_cnt);
        end
        en = 1'b0; din_sr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pdout !== 8'hFE || shift_cnt !== 4'd3 || word_done !== 1'b0) begin
                failures++; $display("FAIL freeze_hold cyc=%0d got=%h cnt=%0d wd=%b exp=fe cnt=3 wd=0",
                                     i, pdout, shift_cnt, word_done);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (pdout !== exp_q[i] || word_done !== (i == 4)) begin
                failures++; $display("FAIL freeze_resume shift=%0d got=%h wd=%b exp=%h wd=%b",
                                     i + 4, pdout, word_done, exp_q[i], (i == 4));
            end
        end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        en = 1'b1; mode = 2'b11; pdin = 8'h00;
        tick();
        din_sr = 1'b1; din_sl = 1'b0;
        // Alternate directions: both share the same word counter.
        for (int i = 1; i <= 16; i++) begin
            mode = (i % 2 == 1) ? 2'b01 : 2'b10;
            tick();
            checks++;
            if (word_done !== (i % 8 == 0) || shift_cnt !== 4'(i % 8)) begin
                failures++; $display("FAIL b2b shift=%0d got wd=%b cnt=%0d exp wd=%b cnt=%0d",
                                     i, word_done, shift_cnt, (i % 8 == 0), i % 8);
            end
        end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_reset_midshift();
        en = 1'b1; mode = 2'b01; din_sr = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (pdout !== 8'hA5 || shift_cnt !== 4'd0 || word_done !== 1'b0) begin
            failures++; $display("FAIL midreset got=%h cnt=%0d wd=%b exp=a5 cnt=0 wd=0", pdout, shift_cnt, word_done);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (word_done !== (i == 8)) begin
                failures++; $display("FAIL midreset_word shift=%0d got=%b exp=%b", i, word_done, (i == 8));
            end
        end
        mode = 2'b00;
        tick();
    endtask

`ifdef UNIV_SR_ROTATE_EN
    task automatic test_rotate();
        logic [7:0] exp_q [8];
        exp_q = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        en = 1'b1; rot = 1'b0; mode = 2'b11; pdin = 8'h81;
        tick();
        rot = 1'b1; mode = 2'b01; din_sr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (pdout !== exp_q[i] || word_done !== (i == 7)) begin
                failures++; $display("FAIL rotate step=%0d got=%h wd=%b exp=%h wd=%b",
                                     i + 1, pdout, word_done, exp_q[i], (i == 7));
            end
        end
        mode = 2'b10; din_sl = 1'b0;
        tick();
        checks++;
        if (pdout !== 8'h03) begin failures++; $display("FAIL rotate_left got=%h exp=03", pdout); end
        rot = 1'b0; mode = 2'b00;
        tick();
    endtask
`endif

    initial begin
`ifdef UNIV_SR_ROTATE_EN
        rot = 1'b0;
`endif
        test_reset();
        test_siso_right();
        test_piso_left();
        test_partial_load();
        test_enable_freeze();
        test_back_to_back();
        test_reset_midshift();
`ifdef UNIV_SR_ROTATE_EN
        test_rotate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
